// File: rtl/adc_cmd_responder.sv
// UART command responder: a command byte selects an ADC channel, one conversion is run,
// and the 16-bit result (or 16'hFFFF on timeout) is returned low byte first.
module adc_cmd_responder #(
    parameter logic [7:0] CMD_BASE = 8'hA1,
    parameter int unsigned DATA_W  = 10,
    parameter int unsigned TIMEOUT = 1200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              conv_start,
    output logic [1:0]        conv_ch,
    input  logic              conv_done,
    input  logic [DATA_W-1:0] conv_data,
    output logic              busy,
    output logic [7:0]        cmd_err_cnt
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        CONVERT,
        SEND_LO,
        SEND_HI
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [7:0]       result_hi;
    logic [7:0]       cmd_off;
    logic             cmd_ok;
    logic [15:0]      conv_ext;

    // Offset arithmetic wraps modulo 256, so the range check is a single compare.
    assign cmd_off = s_axis_tdata - CMD_BASE;
    assign cmd_ok  = (cmd_off < 8'd4);
    assign busy    = ~s_axis_tready;

    always_comb begin
        conv_ext = '0;
        conv_ext[DATA_W-1:0] = conv_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            s_axis_tready <= 1'b1;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            conv_start    <= 1'b0;
            conv_ch       <= '0;
            cmd_err_cnt   <= '0;
            tmo_cnt       <= '0;
            result_hi     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    conv_start <= 1'b0;
                    if (s_axis_tvalid) begin
                        if (cmd_ok) begin
                            conv_ch       <= cmd_off[1:0];
                            conv_start    <= 1'b1;
                            s_axis_tready <= 1'b0;
                            state         <= START;
                        end else if (cmd_err_cnt != 8'hFF) begin
                            cmd_err_cnt <= cmd_err_cnt + 8'd1;
                        end
                    end
                end
                START: begin
                    conv_start <= 1'b0;
                    tmo_cnt    <= '0;
                    state      <= CONVERT;
                end
                CONVERT: begin
                    // conv_done takes priority over an expiring timeout in the same cycle.
                    if (conv_done) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= conv_ext[7:0];
                        result_hi     <= conv_ext[15:8];
                        state         <= SEND_LO;
                    end else if (tmo_cnt == CNT_LAST) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= 8'hFF;
                        result_hi     <= 8'hFF;
                        state         <= SEND_LO;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                SEND_LO: begin
                    if (m_axis_tready) begin
                        m_axis_tdata <= result_hi;
                        state        <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tdata  <= '0;
                        s_axis_tready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    m_axis_tvalid <= 1'b0;
                    conv_start    <= 1'b0;
                    s_axis_tready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/adc_cmd_responder.md
ADC_CMD_RESPONDER -- requirements
Module: adc_cmd_responder

Interface
REQ-001 Parameter CMD_BASE, default 8'hA1: command byte for channel 0; channels 1..3 use CMD_BASE+1..CMD_BASE+3.
REQ-002 Parameter DATA_W, default 10: ADC result width, 1..16.
REQ-003 Parameter TIMEOUT, default 1200: clk cycles allowed for a conversion to complete, >=2.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 s_axis_tdata  input  8  command byte from UART RX.
REQ-007 s_axis_tvalid  input  1  command byte valid.
REQ-008 s_axis_tready  output  1  responder can accept a command byte.
REQ-009 m_axis_tdata  output  8  response byte to UART TX.
REQ-010 m_axis_tvalid  output  1  response byte valid.
REQ-011 m_axis_tready  input  1  UART TX accepts the byte.
REQ-012 conv_start  output  1  one-cycle pulse requesting an ADC conversion.
REQ-013 conv_ch  output  2  channel being converted; held stable from conv_start until the conversion ends.
REQ-014 conv_done  input  1  conversion-complete strobe from the ADC front end.
REQ-015 conv_data  input  DATA_W  result; valid only in the conv_done cycle.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 cmd_err_cnt  output  8  count of rejected command bytes; saturates at 255.

Function
REQ-018 FSM states: IDLE, START, CONVERT, SEND_LO, SEND_HI.
REQ-019 s_axis_tready = 1 only in IDLE; command bytes are never accepted in any other state.
REQ-020 IDLE, handshake with a byte in CMD_BASE..CMD_BASE+3: latch conv_ch = byte-CMD_BASE; go to START.
REQ-021 IDLE, handshake with any other byte: stay in IDLE; cmd_err_cnt +1 unless already 255.
REQ-022 START lasts exactly one cycle with conv_start=1; timeout counter cleared; then CONVERT.
REQ-023 CONVERT: counter increments each cycle; conv_done=1 -> result = conv_data zero-extended to 16 bits; go to SEND_LO.
REQ-024 CONVERT: counter reaches TIMEOUT without conv_done -> result = 16'hFFFF; go to SEND_LO.
REQ-025 conv_done in the same cycle the timeout expires: conv_done wins and the real data is used.
REQ-026 conv_done in any state other than CONVERT is ignored.
REQ-027 SEND_LO: m_axis_tvalid=1, m_axis_tdata=result[7:0]; on m_axis_tready go to SEND_HI.
REQ-028 SEND_HI: m_axis_tvalid=1, m_axis_tdata=result[15:8]; on m_axis_tready go to IDLE.
REQ-029 m_axis_tvalid is never deasserted and m_axis_tdata never changes while m_axis_tvalid=1 and m_axis_tready=0.
REQ-030 Latency:
  - command handshake at cycle t -> conv_start at t+1;
  - conv_done at cycle c -> low byte valid at c+1;
  - with m_axis_tready held high, high byte at c+2 and s_axis_tready=1 at c+3.
REQ-031 Exactly two response bytes per accepted valid command, low byte first; no response for rejected bytes.

Reset
REQ-032 rst=1 forces state IDLE and, on the next edge: s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0, conv_start=0, conv_ch=0, busy=0, cmd_err_cnt=0, timeout counter=0.
REQ-033 rst asserted mid-conversion or mid-response aborts the transaction with no further bytes; a later conv_done is ignored (REQ-026).

Verification
REQ-034 Send 8'hA3, ADC returns conv_done with conv_data=10'h2B7 after 5 cycles, m_axis_tready=1 -> conv_ch=2, one conv_start pulse, bytes 8'hB7 then 8'h02, then s_axis_tready=1.
REQ-035 Send 8'hA1, conv_done never asserted -> after TIMEOUT cycles, bytes 8'hFF, 8'hFF; busy=0 afterwards.
REQ-036 Send 8'h55, then 8'hA4 -> cmd_err_cnt=1, no conv_start for 8'h55, channel-3 response only; 300 invalid bytes -> cmd_err_cnt=255.
REQ-037 Send 8'hA2, conv_data=10'h3FF, m_axis_tready low for 7 cycles on each byte -> tdata stable at 8'hFF then 8'h03, tvalid held high, exactly two transfers.
REQ-038 Send 8'hA1, pulse rst during CONVERT, then conv_done -> no response bytes, all outputs at reset values, next 8'hA2 served normally.
REQ-039 Send 8'hA4, assert conv_done exactly at the timeout cycle with conv_data=10'h001 -> bytes 8'h01, 8'h00.
